// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-serial writer for the CPU's instruction memory.
//
// Accepts a framed byte stream over a valid/ready handshake. The frame is a
// header byte N (word count, 1..DEPTH), then 2N data bytes, high byte first.
// Each pair of data bytes becomes one 16-bit word, written sequentially from
// address 0. The CPU is held via cpu_hold until a complete, valid program is in.
//
// Optional build macro: INSTR_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the data. It must equal the XOR of
//   the header and all data bytes, otherwise the load ends in the error state.
//
// Ports:
//   clk        - clock, all state on the rising edge
//   reset      - asynchronous, active-high reset
//   start      - single-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid   - source presents a byte on in_data
//   in_data    - stream byte
//   in_ready   - loader accepts in_data this cycle (registered, state-only)
//   imem_we    - instruction memory write strobe, one cycle per word
//   imem_waddr - instruction memory write address
//   imem_wdata - instruction word, passed verbatim
//   cpu_hold   - CPU held in reset/stall while high
//   done       - program loaded successfully (level)
//   err        - frame rejected (level)

module instr_mem_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int unsigned CntW     = $clog2(DEPTH + 1);
    localparam logic [7:0]  MaxCount = 8'(DEPTH);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdr   = 3'd1;
    localparam logic [2:0] StHi    = 3'd2;
    localparam logic [2:0] StLo    = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;
    localparam logic [2:0] StErr   = 3'd6;
    localparam logic [2:0] StChk   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_d;
    logic [ADDR_W-1:0] waddr_d;
    logic [15:0]       wdata_d;
    logic              in_ready_d;
    logic              xfer;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        we_d        = 1'b0;
        waddr_d     = imem_waddr;
        wdata_d     = imem_wdata;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                if (xfer) begin
                    if (in_data == 8'd0 || in_data > MaxCount) begin
                        state_d = StErr;
                    end else begin
                        remaining_d = CntW'(in_data);
                        addr_d      = '0;
                        state_d     = StHi;
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = in_data;
`endif
                end
            end
            StHi: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = StLo;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                end
            end
            StLo: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = {hi_q, in_data};
                    state_d = StWrite;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                end
            end
            StWrite: begin
                remaining_d = remaining_q - CntW'(1);
                addr_d      = addr_q + ADDR_W'(1);
                if (remaining_q == CntW'(1)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StDone;
`endif
                end else begin
                    state_d = StHi;
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            StChk: begin
                if (xfer) state_d = (in_data == csum_q) ? StDone : StErr;
            end
`endif
            default: state_d = StIdle;
        endcase
        // Registered from the next state so in_ready depends on state alone.
        in_ready_d = (state_d == StHdr) || (state_d == StHi) ||
                     (state_d == StLo)  || (state_d == StChk);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            addr_q      <= '0;
            hi_q        <= '0;
            in_ready    <= 1'b0;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            in_ready    <= in_ready_d;
            imem_we     <= we_d;
            imem_waddr  <= waddr_d;
            imem_wdata  <= wdata_d;
            cpu_hold    <= (state_d != StDone);
            done        <= (state_d == StDone);
            err         <= (state_d == StErr);
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader. A monitor captures every write
// strobe; each scenario compares the captured writes and status levels with
// what the frame rules predict for the bytes that were sent.

module tb_instr_mem_loader;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [15:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [19:0] obs_q[$];    // captured {addr, data} per write strobe
    logic [7:0]  frame_q[$];  // bytes of the frame under test
    int          viol = 0;
    logic        we_prev = 1'b0;

    instr_mem_loader #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write monitor: a strobe must never last two cycles nor overlap in_ready.
    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back({imem_waddr, imem_wdata});
            if (in_ready || we_prev) viol++;
        end
        we_prev = imem_we;
    end

    task automatic set_frame(input logic [39:0] v, input int len);
        frame_q.delete();
        for (int i = 0; i < len; i++) frame_q.push_back(v[8*(len-1-i) +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL handshake: in_ready=%b after 20 cycles, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Sends frame_q with start pulse and predicts writes/outcome from frame rules.
    task automatic run_frame(input int gap, input string name);
        logic [19:0] exp_q[$];
        logic        exp_ok;
        int          n;
        int          k;
`ifdef INSTR_LOADER_CHECKSUM_EN
        logic [7:0]  csum;
        logic [7:0]  cbyte;
`endif
        n = int'(frame_q[0]);
        obs_q.delete();
        pulse_start();
        checks++;
        if ({in_ready, cpu_hold, done, err} !== 4'b1100) begin
            errors++;
            $display("FAIL %s after start: {ready,hold,done,err}=%b required 1100", name,
                     {in_ready, cpu_hold, done, err});
        end
        if (n == 0 || n > int'(DEPTH)) begin
            send_byte(frame_q[0], gap);
            exp_ok = 1'b0;
        end else begin
            for (int i = 0; i < 1 + 2 * n; i++) send_byte(frame_q[i], gap);
            for (int i = 0; i < n; i++)
                exp_q.push_back({ADDR_W'(i), frame_q[1+2*i], frame_q[2+2*i]});
            exp_ok = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum = 8'h00;
            for (int i = 0; i < 1 + 2 * n; i++) csum ^= frame_q[i];
            cbyte = (frame_q.size() > 1 + 2 * n) ? frame_q[1+2*n] : csum;
            send_byte(cbyte, gap);
            exp_ok = (cbyte == csum);
`endif
        end
        k = 0;
        while (!(done || err) && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write count: got %0d required %0d", name, obs_q.size(),
                     exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s write %0d: got %h required %h", name, i, obs_q[i],
                             exp_q[i]);
                end
            end
        end
        checks++;
        if ({done, err, cpu_hold} !== {exp_ok, !exp_ok, !exp_ok}) begin
            errors++;
            $display("FAIL %s status {done,err,hold}: got %b required %b", name,
                     {done, err, cpu_hold}, {exp_ok, !exp_ok, !exp_ok});
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (5) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err} !==
            {1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset outputs: got %b required %b",
                     {in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err},
                     {1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] csum;
        set_frame(40'h02_1234_ABCD, 5);
        obs_q.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(frame_q[i], 0);
        checks++;
        if ({imem_we, done} !== 2'b10) begin
            errors++;
            $display("FAIL b2b last write cycle {we,done}: got %b required 10", {imem_we, done});
        end
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum = 8'h00;
        for (int i = 0; i < 5; i++) csum ^= frame_q[i];
        send_byte(csum, 0);
`else
        csum = 8'h00;
        @(negedge clk);
`endif
        checks++;
        if ({done, cpu_hold, imem_we} !== 3'b100) begin
            errors++;
            $display("FAIL b2b cycle after write {done,hold,we}: got %b required 100 (csum %h)",
                     {done, cpu_hold, imem_we}, csum);
        end
        checks++;
        if (obs_q.size() != 2) begin
            errors++;
            $display("FAIL b2b write count: got %0d required 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== 20'h0_1234 || obs_q[1] !== 20'h1_ABCD) begin
                errors++;
                $display("FAIL b2b writes: got %h %h required 01234 1abcd", obs_q[0], obs_q[1]);
            end
        end
    endtask

    task automatic test_errors();
        set_frame(40'h00, 1);
        run_frame(0, "hdr0");
        set_frame(40'h11, 1);
        run_frame(0, "hdr17");
        set_frame(40'h01_5A3C, 3);
        run_frame(0, "recover");
        set_frame(40'h10, 1);
        frame_q.delete();
        frame_q.push_back(8'h10);
        for (int i = 0; i < 32; i++) frame_q.push_back(8'(i * 7 + 3));
        run_frame(0, "full16");
    endtask

    task automatic test_gaps();
        set_frame(40'h02_1234_ABCD, 5);
        run_frame(3, "gaps");
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        set_frame(40'h01_1234_27, 4);
        run_frame(0, "csum_ok");
        set_frame(40'h01_1234_00, 4);
        run_frame(0, "csum_bad");
    endtask
`endif

    task automatic test_reset_midload();
        obs_q.delete();
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        checks++;
        if ({in_ready, imem_wdata} !== {1'b1, 16'h5566}) begin
            errors++;
            $display("FAIL midload before reset {ready,wdata}: got %h required 15566",
                     {in_ready, imem_wdata});
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err} !==
            {1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async reset outputs: got %b required %b",
                     {in_ready, imem_we, imem_waddr, imem_wdata, cpu_hold, done, err},
                     {1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0});
        end
        checks++;
        if (obs_q.size() != 1) begin
            errors++;
            $display("FAIL midload write count: got %0d required 1", obs_q.size());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_frame(40'h01_FFEE, 3);
        run_frame(0, "after_reset");
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 5) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
            else
                n = int'($urandom_range(1, DEPTH));
            frame_q.delete();
            frame_q.push_back(8'(n));
            if (n >= 1 && n <= int'(DEPTH))
                for (int i = 0; i < 2 * n; i++) frame_q.push_back(8'($urandom));
            run_frame(int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_errors();
        test_gaps();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        test_random();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL strobe protocol: %0d bad strobes, required 0", viol);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
